// File: rtl/pulse_peak_finder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pulse_peak_finder                                       |
// | Purpose  : scans a filtered sample stream for pulses and reports   |
// |            peak amplitude, peak timestamp and width per pulse.     |
// | Option   : PEAK_PILEUP_FLAG_EN builds the pileup detector.         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module pulse_peak_finder #(
  parameter int SIZE_DATA = 16,
  parameter int SIZE_TS   = 16,
  parameter int MAX_LEN   = 64,
  parameter int SIZE_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZE_DATA-1:0] input_data,
  input  logic [SIZE_DATA-1:0] threshold,
  input  logic [SIZE_HOLD-1:0] holdoff,
  output logic [SIZE_DATA-1:0] peak_amp,
  output logic [SIZE_TS-1:0]   peak_ts,
  output logic [6:0]           peak_width,
  output logic                 peak_valid,
  output logic                 peak_ovf,
  output logic                 pileup,
  output logic                 busy
);

  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIZE_TS-1:0]   ts_q;
  logic [SIZE_DATA-1:0] d0_q;
  logic [SIZE_DATA-1:0] thr_q, thr_d;
  logic [SIZE_DATA-1:0] max_q, max_d;
  logic [SIZE_TS-1:0]   max_ts_q, max_ts_d;
  logic [LEN_W-1:0]     len_q, len_d, w_len_inc;
  logic [SIZE_HOLD-1:0] hold_q, hold_d;
  logic [SIZE_DATA-1:0] amp_q, amp_d;
  logic [SIZE_TS-1:0]   pts_q, pts_d;
  logic [6:0]           width_q, width_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 w_report;

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    max_d     = max_q;
    max_ts_d  = max_ts_q;
    len_d     = len_q;
    hold_d    = hold_q;
    amp_d     = amp_q;
    pts_d     = pts_q;
    width_d   = width_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    w_report  = 1'b0;
    w_len_inc = (len_q == c_len_max) ? c_len_max : len_q + LEN_W'(1);
    case (state_q)
      S_IDLE: begin
        if (d0_q > threshold) begin
          state_d  = S_ARMED;
          thr_d    = threshold;
          max_d    = d0_q;
          max_ts_d = ts_q;
          len_d    = LEN_W'(1);
        end
      end
      S_ARMED: begin
        len_d = w_len_inc;
        // Strict compare keeps the earliest timestamp on a plateau.
        if (d0_q > max_q) begin
          max_d    = d0_q;
          max_ts_d = ts_q;
        end
        if (d0_q <= thr_q) begin
          w_report = 1'b1;
          width_d  = 7'(len_q);
          ovf_d    = 1'b0;
        end else if (w_len_inc == c_len_max) begin
          w_report = 1'b1;
          width_d  = 7'(w_len_inc);
          ovf_d    = 1'b1;
        end
        if (w_report) begin
          valid_d = 1'b1;
          amp_d   = max_d;
          pts_d   = max_ts_d;
          state_d = S_HOLDOFF;
          hold_d  = holdoff;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - SIZE_HOLD'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      d0_q     <= '0;
      thr_q    <= '0;
      max_q    <= '0;
      max_ts_q <= '0;
      len_q    <= '0;
      hold_q   <= '0;
      amp_q    <= '0;
      pts_q    <= '0;
      width_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + SIZE_TS'(1);
      d0_q     <= input_data;
      thr_q    <= thr_d;
      max_q    <= max_d;
      max_ts_q <= max_ts_d;
      len_q    <= len_d;
      hold_q   <= hold_d;
      amp_q    <= amp_d;
      pts_q    <= pts_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign peak_amp   = amp_q;
  assign peak_ts    = pts_q;
  assign peak_width = width_q;
  assign peak_valid = valid_q;
  assign peak_ovf   = ovf_q;
  assign busy       = (state_q != S_IDLE);

`ifdef PEAK_PILEUP_FLAG_EN
  logic [SIZE_DATA-1:0] d1_q;
  logic                 pu_q, pu_d;
  logic                 fell_q, fell_d;
  logic                 pileup_q, pileup_d;
  logic                 w_rise;

  // A rise after a fall while still above threshold marks a second pulse riding on the first.
  always_comb begin
    pu_d     = pu_q;
    fell_d   = fell_q;
    pileup_d = pileup_q;
    w_rise   = (state_q == S_ARMED) && fell_q && (d0_q > d1_q) && (d0_q > thr_q);
    if (state_q == S_ARMED) begin
      if (d0_q < d1_q) begin
        fell_d = 1'b1;
      end else if (w_rise) begin
        fell_d = 1'b0;
      end
    end else begin
      fell_d = 1'b0;
    end
    if (w_report) begin
      pileup_d = pu_q | w_rise;
      pu_d     = 1'b0;
    end else if (w_rise || ((state_q == S_HOLDOFF) && (d0_q > thr_q))) begin
      pu_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q     <= '0;
      pu_q     <= 1'b0;
      fell_q   <= 1'b0;
      pileup_q <= 1'b0;
    end else begin
      d1_q     <= d0_q;
      pu_q     <= pu_d;
      fell_q   <= fell_d;
      pileup_q <= pileup_d;
    end
  end

  assign pileup = pileup_q;
`else
  assign pileup = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_peak_finder.sv
`default_nettype none
// Testbench for pulse_peak_finder: scoreboard of expected reports, checked on every stimulus step.
module tb_pulse_peak_finder;

`ifdef PEAK_PILEUP_FLAG_EN
  localparam logic PU_EN = 1'b1;
`else
  localparam logic PU_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] input_data = '0;
  logic [15:0] threshold = '0;
  logic [7:0]  holdoff = '0;
  logic [15:0] peak_amp;
  logic [7:0]  peak_ts;
  logic [6:0]  peak_width;
  logic        peak_valid;
  logic        peak_ovf;
  logic        pileup;
  logic        busy;

  pulse_peak_finder #(
    .SIZE_DATA(16),
    .SIZE_TS  (8),
    .MAX_LEN  (64),
    .SIZE_HOLD(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .input_data(input_data),
    .threshold (threshold),
    .holdoff   (holdoff),
    .peak_amp  (peak_amp),
    .peak_ts   (peak_ts),
    .peak_width(peak_width),
    .peak_valid(peak_valid),
    .peak_ovf  (peak_ovf),
    .pileup    (pileup),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] amp;
    logic [7:0]  ts;
    logic [6:0]  width;
    logic        ovf;
    logic        pu;
    int          cyc;
  } rep_t;

  rep_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  ts_ref = '0;
  logic [7:0]  last_ts;
  int          last_cyc;

  // Reference timestamp: cleared by reset, free-running otherwise.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ts_ref <= reset ? 8'd0 : ts_ref + 8'd1;
  end

  task automatic push_exp(input logic [15:0] amp, input logic [7:0] ts, input logic [6:0] width,
                          input logic ovf, input logic pu, input int c);
    rep_t e;
    e.amp = amp; e.ts = ts; e.width = width; e.ovf = ovf; e.pu = pu; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; any strobe seen here is matched against the scoreboard.
  task automatic step(input logic [15:0] v);
    rep_t e;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL strobe_missing expected_cyc=%0d now=%0d amp=%0d", e.cyc, cyc, e.amp);
    end
    if (peak_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe_unexpected cyc=%0d amp=%0d ts=%0d", cyc, peak_amp, peak_ts);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (cyc !== e.cyc) begin
          errors++; $display("FAIL strobe_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
        checks++;
        if (peak_amp !== e.amp) begin
          errors++; $display("FAIL peak_amp got=%0d exp=%0d", peak_amp, e.amp);
        end
        checks++;
        if (peak_ts !== e.ts) begin
          errors++; $display("FAIL peak_ts got=%0d exp=%0d", peak_ts, e.ts);
        end
        checks++;
        if (peak_width !== e.width) begin
          errors++; $display("FAIL peak_width got=%0d exp=%0d", peak_width, e.width);
        end
        checks++;
        if (peak_ovf !== e.ovf) begin
          errors++; $display("FAIL peak_ovf got=%0d exp=%0d", peak_ovf, e.ovf);
        end
        checks++;
        if (pileup !== e.pu) begin
          errors++; $display("FAIL pileup got=%0d exp=%0d", pileup, e.pu);
        end
      end
    end
    input_data = v;
    last_ts    = ts_ref + 8'd1;
    last_cyc   = cyc;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(16'd0);
  endtask

  task automatic test_reset();
    threshold = 16'd100;
    holdoff   = 8'd4;
    @(negedge clk);
    reset = 1'b1;
    input_data = 16'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({peak_valid, peak_ovf, pileup, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {peak_valid, peak_ovf, pileup, busy});
    end
    checks++;
    if ({peak_amp, peak_ts, peak_width} !== 31'd0) begin
      errors++; $display("FAIL reset_data amp=%0d ts=%0d width=%0d exp=0", peak_amp, peak_ts, peak_width);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_pulse();
    logic [7:0] t_pk;
    step(16'd0); step(16'd50); step(16'd150);
    step(16'd300); t_pk = last_ts;
    step(16'd200);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_armed got=%0d exp=1", busy);
    end
    step(16'd90);
    push_exp(16'd300, t_pk, 7'd3, 1'b0, 1'b0, last_cyc + 2);
    drain(10);
    checks++;
    if (peak_amp !== 16'd300 || peak_valid !== 1'b0) begin
      errors++; $display("FAIL hold_after_report amp=%0d valid=%0d exp=300/0", peak_amp, peak_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_idle got=%0d exp=0", busy);
    end
  endtask

  task automatic test_plateau();
    logic [7:0] t_pk;
    step(16'd0);
    step(16'd200); t_pk = last_ts;
    step(16'd200);
    step(16'd200);
    threshold = 16'd250;
    step(16'd0);
    push_exp(16'd200, t_pk, 7'd3, 1'b0, 1'b0, last_cyc + 2);
    drain(8);
    threshold = 16'd100;
    step(16'd100); step(16'd100); step(16'd100);
    drain(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL equal_threshold_armed busy=%0d exp=0", busy);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] t0, t1;
    t0 = '0; t1 = '0;
    holdoff = 8'd4;
    step(16'd0);
    for (int i = 0; i < 100; i++) begin
      step(16'd500);
      if (i == 0) t0 = last_ts;
      if (i == 63) push_exp(16'd500, t0, 7'd64, 1'b1, 1'b0, last_cyc + 2);
      if (i == 69) t1 = last_ts;
    end
    step(16'd0);
    push_exp(16'd500, t1, 7'd31, 1'b0, PU_EN, last_cyc + 2);
    drain(12);
  endtask

  task automatic test_pileup();
    logic [7:0] ta, tc;
    holdoff = 8'd10;
    step(16'd0); step(16'd200);
    step(16'd300); ta = last_ts;
    step(16'd50);
    push_exp(16'd300, ta, 7'd2, 1'b0, 1'b0, last_cyc + 2);
    step(16'd0); step(16'd0); step(16'd250); step(16'd250);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_holdoff got=%0d exp=1", busy);
    end
    step(16'd0);
    drain(20);
    step(16'd150); tc = last_ts;
    step(16'd0);
    push_exp(16'd150, tc, 7'd1, 1'b0, PU_EN, last_cyc + 2);
    drain(15);
  endtask

  task automatic test_reset_mid();
    logic [7:0] t_pk;
    holdoff = 8'd4;
    step(16'd0); step(16'd50); step(16'd150); step(16'd300);
    @(negedge clk);
    reset = 1'b1;
    input_data = 16'd200;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || peak_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid busy=%0d valid=%0d exp=0/0", busy, peak_valid);
    end
    checks++;
    if (peak_amp !== 16'd0 || peak_width !== 7'd0) begin
      errors++; $display("FAIL reset_mid_outputs amp=%0d width=%0d exp=0/0", peak_amp, peak_width);
    end
    reset = 1'b0;
    input_data = 16'd0;
    step(16'd0); step(16'd0);
    step(16'd120); t_pk = last_ts;
    step(16'd0);
    push_exp(16'd120, t_pk, 7'd1, 1'b0, 1'b0, last_cyc + 2);
    drain(8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta, tb;
    holdoff = 8'd0;
    step(16'd0);
    step(16'd150); ta = last_ts;
    step(16'd50);
    push_exp(16'd150, ta, 7'd1, 1'b0, 1'b0, last_cyc + 2);
    step(16'd200);
    step(16'd180); tb = last_ts;
    step(16'd0);
    push_exp(16'd180, tb, 7'd1, 1'b0, PU_EN, last_cyc + 2);
    drain(6);
  endtask

  task automatic test_ts_wrap();
    logic [7:0] t_pk;
    holdoff = 8'd2;
    for (int p = 0; p < 20; p++) begin
      repeat (16) step(16'd0);
      step(16'd120);
      step(16'd180); t_pk = last_ts;
      step(16'd140);
      step(16'd0);
      push_exp(16'd180, t_pk, 7'd3, 1'b0, 1'b0, last_cyc + 2);
    end
    drain(6);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_plateau();
    test_overflow();
    test_pileup();
    test_reset_mid();
    test_back_to_back();
    test_ts_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
